vga_fb_arbiter: RTL

//  Sequences and shares one single-port 1bpp framebuffer RAM between display scan-out and two

---
 rtl/vga_fb_arbiter_pkg.sv | 25 ++
 rtl/vga_fb_arbiter_if.sv | 43 ++++
 rtl/vga_fb_arbiter_rr_arb2.sv | 39 +++
 rtl/vga_fb_arbiter.sv | 93 +++++++++
 4 files changed

// File: rtl/vga_fb_arbiter_pkg.sv
// Shared 640x480 VGA timing constants, framebuffer geometry and writer word type.
// The timing generator uses the same constants.
package vga_fb_arbiter_pkg;

   localparam int unsigned HDisplay = 640;
   localparam int unsigned HTotal   = 800;
   localparam int unsigned VDisplay = 480;
   localparam int unsigned VTotal   = 525;
   localparam int unsigned Wpl      = HDisplay / 8;
   localparam int unsigned FbDepth  = Wpl * VDisplay;
   localparam int unsigned AddrW    = 16;

   typedef logic [AddrW-1:0] addr_t;

   typedef struct packed {
      addr_t      addr;
      logic [7:0] data;
   } wr_word_t;

   // line * 80 as shift-and-add
   function automatic addr_t line_base(input logic [9:0] line);
      return (addr_t'(line) << 6) + (addr_t'(line) << 4);
   endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Timing inputs, delayed video outputs, RAM port and writer ports of the framebuffer arbiter.
interface vga_fb_arbiter_if;
   import vga_fb_arbiter_pkg::*;

   logic [9:0] x;
   logic [9:0] y;
   logic       active_video;
   logic       hsync;
   logic       vsync;

   logic       hsync_out;
   logic       vsync_out;
   logic       active_out;
   logic       pixel_out;

   logic       ram_en;
   logic       ram_we;
   addr_t      ram_addr;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata;

   logic [1:0] wr_req;
   addr_t      wr_addr0;
   addr_t      wr_addr1;
   logic [7:0] wr_data0;
   logic [7:0] wr_data1;
   logic [1:0] wr_gnt;

   modport master (
      input  x, y, active_video, hsync, vsync, ram_rdata,
      input  wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
      output hsync_out, vsync_out, active_out, pixel_out,
      output ram_en, ram_we, ram_addr, ram_wdata, wr_gnt
   );

   modport slave (
      output x, y, active_video, hsync, vsync, ram_rdata,
      output wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
      input  hsync_out, vsync_out, active_out, pixel_out,
      input  ram_en, ram_we, ram_addr, ram_wdata, wr_gnt
   );

endinterface

// File: rtl/vga_fb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; inhibit blocks all grants and leaves the pointer untouched.
module vga_fb_arbiter_rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       inhibit_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic ptr_q, ptr_d;

   always_comb begin
      gnt_o = 2'b00;
      ptr_d = ptr_q;
      if (!rst_i && !inhibit_i) begin
         case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
         endcase
      end
      // Favour the writer that was not just served
      if (gnt_o[0]) begin
         ptr_d = 1'b1;
      end else if (gnt_o[1]) begin
         ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port 1bpp framebuffer RAM between display scan-out (one word per 8 pixels)
// and two round-robin writers; the fetched word is shifted out as a registered pixel stream.
module vga_fb_arbiter
   import vga_fb_arbiter_pkg::*;
(
   input logic              clk_25MHz,
   input logic              reset,
   vga_fb_arbiter_if.master bus
);

   logic [9:0] y_next;
   logic       fetch_grp;
   logic       fetch_line;
   logic       fetch;
   addr_t      fetch_addr;
   logic [1:0] gnt;
   wr_word_t   wr_sel;

   logic       fetch_q;
   logic [7:0] shreg_q, shreg_d;
   logic       pixel_q, pixel_d;
   logic       hsync_q, vsync_q, active_q;

   // Fetch two pixels ahead of the group boundary; x==798 prefetches group 0 of the next line
   always_comb begin
      y_next     = (bus.y == 10'(VTotal - 1)) ? 10'd0 : bus.y + 10'd1;
      fetch_grp  = (bus.x[2:0] == 3'd6) && (bus.x < 10'(HDisplay - 8)) &&
                   (bus.y < 10'(VDisplay));
      fetch_line = (bus.x == 10'(HTotal - 2)) && (y_next < 10'(VDisplay));
      fetch      = fetch_grp | fetch_line;
      fetch_addr = fetch_line ? line_base(y_next)
                              : line_base(bus.y) + addr_t'((bus.x + 10'd2) >> 3);
   end

   vga_fb_arbiter_rr_arb2 u_arb (
      .clk_i     (clk_25MHz),
      .rst_i     (reset),
      .inhibit_i (fetch),
      .req_i     (bus.wr_req),
      .gnt_o     (gnt)
   );

   assign bus.wr_gnt = gnt;

   always_comb begin
      wr_sel.addr   = gnt[1] ? bus.wr_addr1 : bus.wr_addr0;
      wr_sel.data   = gnt[1] ? bus.wr_data1 : bus.wr_data0;
      bus.ram_en    = 1'b0;
      bus.ram_we    = 1'b0;
      bus.ram_addr  = fetch_addr;
      bus.ram_wdata = 8'h00;
      if (!reset) begin
         if (fetch) begin
            bus.ram_en = 1'b1;
         end else if (|gnt) begin
            // Out-of-range writes are granted but never reach the RAM
            bus.ram_addr  = wr_sel.addr;
            bus.ram_wdata = wr_sel.data;
            bus.ram_en    = (wr_sel.addr < addr_t'(FbDepth));
            bus.ram_we    = (wr_sel.addr < addr_t'(FbDepth));
         end
      end
   end

   always_comb begin
      shreg_d = fetch_q ? bus.ram_rdata : shreg_q;
      pixel_d = bus.active_video ? shreg_q[3'd7 - bus.x[2:0]] : 1'b0;
   end

   always_ff @(posedge clk_25MHz) begin
      if (reset) begin
         fetch_q  <= 1'b0;
         shreg_q  <= 8'h00;
         pixel_q  <= 1'b0;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         active_q <= 1'b0;
      end else begin
         fetch_q  <= fetch;
         shreg_q  <= shreg_d;
         pixel_q  <= pixel_d;
         hsync_q  <= bus.hsync;
         vsync_q  <= bus.vsync;
         active_q <= bus.active_video;
      end
   end

   assign bus.pixel_out  = pixel_q;
   assign bus.hsync_out  = hsync_q;
   assign bus.vsync_out  = vsync_q;
   assign bus.active_out = active_q;

endmodule
